// File: rtl/spi_reg_arbiter.sv
// Arbitrates a synchronized SPI slave and a local requester onto one register-bank port.
// SPI requests wait in a one-deep slot; a streak limit keeps the local side from starving.
module spi_reg_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 8,
    parameter int MAX_SPI_WINS = 4
) (
    input  logic          clk_32m,
    input  logic          reset,
    input  logic          spi_we_p,
    input  logic          spi_re_p,
    input  logic [AW-1:0] spi_addr,
    input  logic [DW-1:0] spi_wdat,
    output logic [DW-1:0] spi_rdat,
    output logic          spi_rvalid,
    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [DW-1:0] loc_wdat,
    output logic          loc_gnt,
    output logic [DW-1:0] loc_rdat,
    output logic          loc_rvalid,
    output logic          bus_en,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdat,
    input  logic [DW-1:0] bus_rdat,
    output logic          spi_ovf
);

    localparam logic [3:0] MAX_WINS = 4'(MAX_SPI_WINS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t        state_r, state_nxt;

    logic          slot_full_r, slot_full_nxt;
    logic          slot_we_r, slot_we_nxt;
    logic [AW-1:0] slot_addr_r, slot_addr_nxt;
    logic [DW-1:0] slot_wdat_r, slot_wdat_nxt;
    logic          spi_ovf_r, spi_ovf_nxt;
    logic [3:0]    streak_r, streak_nxt;
    logic          cur_spi_r, cur_spi_nxt;

    logic          bus_en_r, bus_en_nxt;
    logic          bus_we_r, bus_we_nxt;
    logic [AW-1:0] bus_addr_r, bus_addr_nxt;
    logic [DW-1:0] bus_wdat_r, bus_wdat_nxt;
    logic          loc_gnt_r, loc_gnt_nxt;
    logic          spi_rvalid_r, spi_rvalid_nxt;
    logic          loc_rvalid_r, loc_rvalid_nxt;
    logic [DW-1:0] spi_rdat_r, spi_rdat_nxt;
    logic [DW-1:0] loc_rdat_r, loc_rdat_nxt;

    logic          pulse_s;
    logic          spi_wins_s;
    logic          grant_spi_s;
    logic          grant_loc_s;

    assign pulse_s    = spi_we_p | spi_re_p;
    // Local side only overrides SPI once the SPI streak has hit its limit.
    assign spi_wins_s = slot_full_r & ~((streak_r == MAX_WINS) & loc_req);

    // FSM next state, grant decision and next values of all registered outputs.
    always_comb begin
        state_nxt      = state_r;
        cur_spi_nxt    = cur_spi_r;
        grant_spi_s    = 1'b0;
        grant_loc_s    = 1'b0;
        bus_en_nxt     = 1'b0;
        bus_we_nxt     = 1'b0;
        bus_addr_nxt   = '0;
        bus_wdat_nxt   = '0;
        loc_gnt_nxt    = 1'b0;
        spi_rvalid_nxt = 1'b0;
        loc_rvalid_nxt = 1'b0;
        spi_rdat_nxt   = spi_rdat_r;
        loc_rdat_nxt   = loc_rdat_r;
        case (state_r)
            IDLE: begin
                if (slot_full_r || loc_req) begin
                    state_nxt  = ISSUE;
                    bus_en_nxt = 1'b1;
                    if (spi_wins_s) begin
                        grant_spi_s  = 1'b1;
                        cur_spi_nxt  = 1'b1;
                        bus_we_nxt   = slot_we_r;
                        bus_addr_nxt = slot_addr_r;
                        bus_wdat_nxt = slot_wdat_r;
                    end else begin
                        grant_loc_s  = 1'b1;
                        cur_spi_nxt  = 1'b0;
                        loc_gnt_nxt  = 1'b1;
                        bus_we_nxt   = loc_we;
                        bus_addr_nxt = loc_addr;
                        bus_wdat_nxt = loc_wdat;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                // bus_we_r still holds the latched direction during the issue cycle.
                if (bus_we_r) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_nxt = IDLE;
                if (cur_spi_r) begin
                    spi_rvalid_nxt = 1'b1;
                    spi_rdat_nxt   = bus_rdat;
                end else begin
                    loc_rvalid_nxt = 1'b1;
                    loc_rdat_nxt   = bus_rdat;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pending SPI slot: load on pulse, free on grant, flag overrun when full and not draining.
    always_comb begin
        slot_full_nxt = slot_full_r;
        slot_we_nxt   = slot_we_r;
        slot_addr_nxt = slot_addr_r;
        slot_wdat_nxt = slot_wdat_r;
        spi_ovf_nxt   = spi_ovf_r;
        if (pulse_s) begin
            if (slot_full_r && !grant_spi_s) begin
                spi_ovf_nxt = 1'b1;
            end else begin
                slot_full_nxt = 1'b1;
                slot_we_nxt   = spi_we_p;
                slot_addr_nxt = spi_addr;
                slot_wdat_nxt = spi_wdat;
            end
        end else if (grant_spi_s) begin
            slot_full_nxt = 1'b0;
        end else begin
            slot_full_nxt = slot_full_r;
        end
    end

    // Count SPI grants taken while the local side is waiting.
    always_comb begin
        if (!loc_req) begin
            streak_nxt = 4'd0;
        end else if (grant_loc_s) begin
            streak_nxt = 4'd0;
        end else if (grant_spi_s && (streak_r < MAX_WINS)) begin
            streak_nxt = streak_r + 4'd1;
        end else begin
            streak_nxt = streak_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_32m or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            slot_full_r  <= 1'b0;
            slot_we_r    <= 1'b0;
            slot_addr_r  <= '0;
            slot_wdat_r  <= '0;
            spi_ovf_r    <= 1'b0;
            streak_r     <= 4'd0;
            cur_spi_r    <= 1'b0;
            bus_en_r     <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= '0;
            bus_wdat_r   <= '0;
            loc_gnt_r    <= 1'b0;
            spi_rvalid_r <= 1'b0;
            loc_rvalid_r <= 1'b0;
            spi_rdat_r   <= '0;
            loc_rdat_r   <= '0;
        end else begin
            state_r      <= state_nxt;
            slot_full_r  <= slot_full_nxt;
            slot_we_r    <= slot_we_nxt;
            slot_addr_r  <= slot_addr_nxt;
            slot_wdat_r  <= slot_wdat_nxt;
            spi_ovf_r    <= spi_ovf_nxt;
            streak_r     <= streak_nxt;
            cur_spi_r    <= cur_spi_nxt;
            bus_en_r     <= bus_en_nxt;
            bus_we_r     <= bus_we_nxt;
            bus_addr_r   <= bus_addr_nxt;
            bus_wdat_r   <= bus_wdat_nxt;
            loc_gnt_r    <= loc_gnt_nxt;
            spi_rvalid_r <= spi_rvalid_nxt;
            loc_rvalid_r <= loc_rvalid_nxt;
            spi_rdat_r   <= spi_rdat_nxt;
            loc_rdat_r   <= loc_rdat_nxt;
        end
    end

    assign bus_en     = bus_en_r;
    assign bus_we     = bus_we_r;
    assign bus_addr   = bus_addr_r;
    assign bus_wdat   = bus_wdat_r;
    assign loc_gnt    = loc_gnt_r;
    assign spi_rvalid = spi_rvalid_r;
    assign loc_rvalid = loc_rvalid_r;
    assign spi_rdat   = spi_rdat_r;
    assign loc_rdat   = loc_rdat_r;
    assign spi_ovf    = spi_ovf_r;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Bench for spi_reg_arbiter: a transaction-scheduling reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_spi_reg_arbiter;

    localparam int MAXW = 4;

    logic       clk_32m = 1'b0;
    logic       reset = 1'b1;
    logic       spi_we_p = 1'b0, spi_re_p = 1'b0;
    logic [6:0] spi_addr = '0;
    logic [7:0] spi_wdat = '0;
    logic [7:0] spi_rdat;
    logic       spi_rvalid;
    logic       loc_req = 1'b0, loc_we = 1'b0;
    logic [6:0] loc_addr = '0;
    logic [7:0] loc_wdat = '0;
    logic       loc_gnt;
    logic [7:0] loc_rdat;
    logic       loc_rvalid;
    logic       bus_en, bus_we;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdat;
    logic [7:0] bus_rdat = '0;
    logic       spi_ovf;

    spi_reg_arbiter #(.AW(7), .DW(8), .MAX_SPI_WINS(MAXW)) dut (
        .clk_32m(clk_32m), .reset(reset),
        .spi_we_p(spi_we_p), .spi_re_p(spi_re_p), .spi_addr(spi_addr), .spi_wdat(spi_wdat),
        .spi_rdat(spi_rdat), .spi_rvalid(spi_rvalid),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdat(loc_wdat),
        .loc_gnt(loc_gnt), .loc_rdat(loc_rdat), .loc_rvalid(loc_rvalid),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdat(bus_wdat),
        .bus_rdat(bus_rdat), .spi_ovf(spi_ovf)
    );

    always #16 clk_32m = ~clk_32m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Expected output events scheduled for a future cycle.
    typedef struct packed {
        logic       bus_en;
        logic       bus_we;
        logic [6:0] addr;
        logic [7:0] wdat;
        logic       loc_gnt;
        logic       rv_spi;
        logic       rv_loc;
        logic [7:0] rdat;
    } ev_t;
    ev_t ring [8];

    logic       m_slot_full, m_slot_we, m_ovf;
    logic [6:0] m_slot_addr;
    logic [7:0] m_slot_wdat, exp_spi_rdat, exp_loc_rdat;
    int         m_streak, m_free, m_cap;
    logic       m_cap_spi;

    // Stimulus applied on the next tick.
    logic       d_rst = 1'b1, d_swe = 1'b0, d_sre = 1'b0, d_lr = 1'b0, d_lwe = 1'b0;
    logic [6:0] d_sa = '0, d_la = '0;
    logic [7:0] d_sw = '0, d_lw = '0, d_brd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ring[i] = '0;
        m_slot_full = 1'b0; m_slot_we = 1'b0; m_slot_addr = '0; m_slot_wdat = '0;
        m_ovf = 1'b0; m_streak = 0; m_free = 0; m_cap = -1; m_cap_spi = 1'b0;
        exp_spi_rdat = '0; exp_loc_rdat = '0;
    endtask

    // Compare this cycle's outputs with the model, then advance the model over the coming edge.
    task automatic compare_and_step();
        ev_t  e;
        int   k, n;
        logic consumed, spi_win, we;
        k = cyc % 8;
        if (reset) model_reset();
        e = ring[k];
        ring[k] = '0;
        if (e.rv_spi) exp_spi_rdat = e.rdat;
        if (e.rv_loc) exp_loc_rdat = e.rdat;
        chk("bus_en",     32'(bus_en),     32'(e.bus_en));
        chk("bus_we",     32'(bus_we),     32'(e.bus_we));
        chk("bus_addr",   32'(bus_addr),   32'(e.addr));
        chk("bus_wdat",   32'(bus_wdat),   32'(e.wdat));
        chk("loc_gnt",    32'(loc_gnt),    32'(e.loc_gnt));
        chk("spi_rvalid", 32'(spi_rvalid), 32'(e.rv_spi));
        chk("loc_rvalid", 32'(loc_rvalid), 32'(e.rv_loc));
        chk("spi_rdat",   32'(spi_rdat),   32'(exp_spi_rdat));
        chk("loc_rdat",   32'(loc_rdat),   32'(exp_loc_rdat));
        chk("spi_ovf",    32'(spi_ovf),    32'(m_ovf));
        if (!reset) begin
            n = (cyc + 1) % 8;
            consumed = 1'b0;
            if (cyc == m_cap) begin
                if (m_cap_spi) ring[n].rv_spi = 1'b1;
                else           ring[n].rv_loc = 1'b1;
                ring[n].rdat = bus_rdat;
                m_cap = -1;
            end
            if (cyc >= m_free && (m_slot_full || loc_req)) begin
                spi_win = m_slot_full && !(m_streak == MAXW && loc_req);
                ring[n].bus_en = 1'b1;
                if (spi_win) begin
                    ring[n].bus_we = m_slot_we; ring[n].addr = m_slot_addr; ring[n].wdat = m_slot_wdat;
                    we = m_slot_we;
                    consumed = 1'b1;
                    if (loc_req && m_streak < MAXW) m_streak++;
                end else begin
                    ring[n].bus_we = loc_we; ring[n].addr = loc_addr; ring[n].wdat = loc_wdat;
                    ring[n].loc_gnt = 1'b1;
                    we = loc_we;
                    m_streak = 0;
                end
                m_free = cyc + (we ? 2 : 3);
                if (!we) begin
                    m_cap = cyc + 2;
                    m_cap_spi = spi_win;
                end
            end
            if (!loc_req) m_streak = 0;
            if (spi_we_p || spi_re_p) begin
                if (m_slot_full && !consumed) begin
                    m_ovf = 1'b1;
                end else begin
                    m_slot_full = 1'b1; m_slot_we = spi_we_p;
                    m_slot_addr = spi_addr; m_slot_wdat = spi_wdat;
                end
            end else if (consumed) begin
                m_slot_full = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_32m);
        #1;
        reset = d_rst; spi_we_p = d_swe; spi_re_p = d_sre; spi_addr = d_sa; spi_wdat = d_sw;
        loc_req = d_lr; loc_we = d_lwe; loc_addr = d_la; loc_wdat = d_lw; bus_rdat = d_brd;
        @(negedge clk_32m);
        compare_and_step();
        cyc++;
        d_swe = 1'b0;
        d_sre = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int cnt_a, cnt_b, cnt_c, r;
    logic seen;

    initial begin
        model_reset();
        quiet(3);
        d_rst = 1'b0;
        quiet(3);

        // Read of 0x7D: bus_en two cycles after the pulse, data returned two cycles later.
        d_sre = 1'b1; d_sa = 7'h7D; d_brd = 8'h00;
        tick();
        tick();
        chk("rd_bus_en_c1", 32'(bus_en), 32'd0);
        tick();
        chk("rd_bus_en_c2", 32'(bus_en), 32'd1);
        chk("rd_bus_addr_c2", 32'(bus_addr), 32'h7D);
        d_brd = 8'h5A;
        tick();
        chk("rd_rvalid_c3", 32'(spi_rvalid), 32'd0);
        d_brd = 8'h00;
        tick();
        chk("rd_rvalid_c4", 32'(spi_rvalid), 32'd1);
        chk("rd_rdat_c4", 32'(spi_rdat), 32'h5A);
        quiet(3);

        // Write of 0x33 to 0x7D.
        d_swe = 1'b1; d_sa = 7'h7D; d_sw = 8'h33;
        tick();
        tick();
        tick();
        chk("wr_bus_en", 32'(bus_en), 32'd1);
        chk("wr_bus_we", 32'(bus_we), 32'd1);
        chk("wr_bus_wdat", 32'(bus_wdat), 32'h33);
        cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (spi_rvalid) cnt_a++;
        end
        chk("wr_no_rvalid", 32'(cnt_a), 32'd0);

        // Local read held while SPI reads arrive every third cycle.
        d_sre = 1'b1; d_sa = 7'h01;
        tick();
        d_lr = 1'b1; d_lwe = 1'b0; d_la = 7'h11;
        cnt_a = 0; seen = 1'b0;
        for (int i = 1; i < 30; i++) begin
            if (i % 3 == 0 && i <= 12) begin
                d_sre = 1'b1; d_sa = 7'(i);
            end
            tick();
            if (bus_en && !loc_gnt && !seen) cnt_a++;
            if (loc_gnt) begin
                seen = 1'b1;
                d_lr = 1'b0;
            end
        end
        chk("streak_spi_grants", 32'(cnt_a), 32'd4);
        chk("streak_loc_gnt", 32'(seen), 32'd1);
        chk("streak_ovf", 32'(spi_ovf), 32'd0);
        quiet(3);

        // Pulse in the same cycle the slot drains: both requests served, no overrun.
        d_sre = 1'b1; d_sa = 7'h01;
        tick();
        d_sre = 1'b1; d_sa = 7'h02;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_en) cnt_a++;
            if (spi_rvalid) cnt_b++;
        end
        chk("reload_bus_en", 32'(cnt_a), 32'd2);
        chk("reload_rvalid", 32'(cnt_b), 32'd2);
        chk("reload_ovf", 32'(spi_ovf), 32'd0);

        // Two SPI pulses back to back during a local read: second one dropped.
        d_lr = 1'b1; d_lwe = 1'b0; d_la = 7'h22;
        tick();
        d_sre = 1'b1; d_sa = 7'h10;
        tick();
        chk("ovf_loc_gnt", 32'(loc_gnt), 32'd1);
        d_lr = 1'b0;
        d_sre = 1'b1; d_sa = 7'h20;
        tick();
        tick();
        chk("ovf_set", 32'(spi_ovf), 32'd1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_en && bus_addr == 7'h20) cnt_a++;
            if (bus_en && bus_addr == 7'h10) cnt_c++;
            if (spi_rvalid) cnt_b++;
        end
        chk("ovf_dropped", 32'(cnt_a), 32'd0);
        chk("ovf_kept", 32'(cnt_c), 32'd1);
        chk("ovf_one_rvalid", 32'(cnt_b), 32'd1);
        chk("ovf_sticky", 32'(spi_ovf), 32'd1);

        // Reset during RD_WAIT abandons the read; a fresh read then has normal latency.
        d_sre = 1'b1; d_sa = 7'h05;
        tick();
        tick();
        tick();
        d_rst = 1'b1;
        tick();
        chk("rst_rvalid", 32'(spi_rvalid), 32'd0);
        chk("rst_ovf", 32'(spi_ovf), 32'd0);
        chk("rst_bus_en", 32'(bus_en), 32'd0);
        tick();
        chk("rst_rvalid2", 32'(spi_rvalid), 32'd0);
        d_rst = 1'b0;
        tick();
        chk("post_rst_rvalid", 32'(spi_rvalid), 32'd0);
        d_sre = 1'b1; d_sa = 7'h7D;
        tick();
        tick();
        tick();
        chk("post_rst_bus_en", 32'(bus_en), 32'd1);
        d_brd = 8'hA5;
        tick();
        d_brd = 8'h00;
        tick();
        chk("post_rst_rvalid4", 32'(spi_rvalid), 32'd1);
        chk("post_rst_rdat", 32'(spi_rdat), 32'hA5);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            d_brd = 8'($urandom);
            if (d_rst) begin
                if ($urandom_range(2, 0) == 0) d_rst = 1'b0;
            end else if ($urandom_range(299, 0) == 0) begin
                d_rst = 1'b1;
                d_lr = 1'b0;
            end
            if (!d_rst) begin
                if ($urandom_range(4, 0) == 0) begin
                    r = $urandom_range(3, 0);
                    d_swe = (r == 0) || (r == 3);
                    d_sre = (r != 0);
                    d_sa = 7'($urandom);
                    d_sw = 8'($urandom);
                end
                if (!d_lr) begin
                    if ($urandom_range(3, 0) == 0) begin
                        d_lr = 1'b1;
                        d_lwe = 1'($urandom);
                        d_la = 7'($urandom);
                        d_lw = 8'($urandom);
                    end
                end else if ($urandom_range(39, 0) == 0) begin
                    d_lr = 1'b0;
                end
            end
            tick();
            if (loc_gnt) d_lr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
